// File: rtl/aurora_prbs_checker.sv
// ---------------------------------------------------------------------------
// aurora_prbs_checker
// Checks a 64-bit-per-beat PRBS stream (x^64 + x^63 + x^61 + x^60 style
// feedback on bits 63/62/60/59). It seeds from the stream, declares lock
// after LOCK_THRESH consecutive correct words and then free-runs its own
// expected word. It counts checked and failing words while locked, and
// drops lock after UNLOCK_THRESH consecutive failures.
// ---------------------------------------------------------------------------
module aurora_prbs_checker #(
    parameter int unsigned LOCK_THRESH   = 16,
    parameter int unsigned UNLOCK_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [63:0] i_tdata,
    input  logic        i_tvalid,
    output logic        locked,
    output logic [47:0] samps,
    output logic [47:0] errors
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [47:0] CNT_MAX    = 48'hFFFF_FFFF_FFFF;
    localparam logic [7:0]  LOCK_RUN   = LOCK_THRESH[7:0];
    localparam logic [7:0]  UNLOCK_RUN = UNLOCK_THRESH[7:0];

    // One step of the PRBS generator: shift left, new LSB from the taps.
    function automatic logic [63:0] prbs_step(input logic [63:0] x);
        prbs_step = {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
    endfunction

    // Saturating increment so the statistics never wrap back to zero.
    function automatic logic [47:0] sat_inc(input logic [47:0] c);
        if (c == CNT_MAX) begin
            sat_inc = c;
        end else begin
            sat_inc = c + 48'd1;
        end
    endfunction

    logic [1:0]  state_q,  state_d;
    logic [63:0] exp_q,    exp_d;
    logic [7:0]  run_q,    run_d;
    logic        seeded_q, seeded_d;
    logic [47:0] samps_q,  samps_d;
    logic [47:0] errors_q, errors_d;
    logic        locked_q;

    logic [7:0]  run_inc_s;
    logic        match_s;
    logic        zero_s;
    logic [63:0] reseed_s;

    assign run_inc_s = run_q + 8'd1;
    assign match_s   = (i_tdata == exp_q);
    assign zero_s    = (i_tdata == 64'd0);
    assign reseed_s  = prbs_step(i_tdata);

    // Next-state, expected-word, run-length and statistics logic.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        run_d    = run_q;
        seeded_d = seeded_q;
        samps_d  = samps_q;
        errors_d = errors_q;

        if (!enable) begin
            // Disabling parks the checker; beats in this cycle are dropped
            // and the statistics stay readable.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SEARCH;
                    samps_d  = 48'd0;
                    errors_d = 48'd0;
                    run_d    = 8'd0;
                    seeded_d = 1'b0;
                end

                ST_SEARCH: begin
                    if (i_tvalid) begin
                        if (!seeded_q) begin
                            exp_d    = reseed_s;
                            seeded_d = 1'b1;
                            run_d    = 8'd0;
                        end else if (match_s && !zero_s) begin
                            exp_d = reseed_s;
                            if (run_inc_s == LOCK_RUN) begin
                                state_d = ST_LOCKED;
                                run_d   = 8'd0;
                            end else begin
                                run_d = run_inc_s;
                            end
                        end else begin
                            // Mismatch or the degenerate all-zero word:
                            // restart the run from this word.
                            exp_d = reseed_s;
                            run_d = 8'd0;
                        end
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end

                ST_LOCKED: begin
                    if (i_tvalid) begin
                        samps_d = sat_inc(samps_q);
                        // Free-run: never trust received data once locked.
                        exp_d   = prbs_step(exp_q);
                        if (!match_s) begin
                            errors_d = sat_inc(errors_q);
                            if (run_inc_s == UNLOCK_RUN) begin
                                state_d  = ST_SEARCH;
                                seeded_d = 1'b0;
                                run_d    = 8'd0;
                            end else begin
                                run_d = run_inc_s;
                            end
                        end else begin
                            run_d = 8'd0;
                        end
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            exp_q    <= 64'd0;
            run_q    <= 8'd0;
            seeded_q <= 1'b0;
            samps_q  <= 48'd0;
            errors_q <= 48'd0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            run_q    <= run_d;
            seeded_q <= seeded_d;
            samps_q  <= samps_d;
            errors_q <= errors_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

    assign locked = locked_q;
    assign samps  = samps_q;
    assign errors = errors_q;

endmodule

// File: tb/tb_aurora_prbs_checker.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for aurora_prbs_checker (default thresholds
// LOCK_THRESH=16, UNLOCK_THRESH=4).
// ---------------------------------------------------------------------------
module tb_aurora_prbs_checker;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [63:0] i_tdata;
    logic        i_tvalid;
    logic        locked;
    logic [47:0] samps;
    logic [47:0] errors;

    int n_cmp;
    int n_err;
    logic [63:0] w;

    aurora_prbs_checker dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .i_tdata  (i_tdata),
        .i_tvalid (i_tvalid),
        .locked   (locked),
        .samps    (samps),
        .errors   (errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] f(input logic [63:0] x);
        f = {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send_word(input logic [63:0] d);
        i_tvalid = 1'b1;
        i_tdata  = d;
        tick();
        i_tvalid = 1'b0;
    endtask

    task automatic send_true();
        send_word(w);
        w = f(w);
    endtask

    task automatic send_bad();
        send_word(w ^ 64'h1);
        w = f(w);
    endtask

    initial begin
        int vcnt;
        n_cmp    = 0;
        n_err    = 0;
        // Reset overrides enable and a valid beat.
        rst      = 1'b1;
        enable   = 1'b1;
        i_tvalid = 1'b1;
        i_tdata  = 64'h1;
        tick();
        tick();
        chk("rst_locked", {63'd0, locked}, 64'd0);
        chk("rst_samps",  {16'd0, samps},  64'd0);
        chk("rst_errors", {16'd0, errors}, 64'd0);

        // Release reset: IDLE -> SEARCH on this edge, no beat.
        rst      = 1'b0;
        i_tvalid = 1'b0;
        tick();

        // W0 seeds, W1..W16 match; lock after W16.
        w = 64'h1;
        for (int i = 0; i < 16; i++) send_true();
        chk("prelock_w15", {63'd0, locked}, 64'd0);
        send_true();
        chk("lock_w16", {63'd0, locked}, 64'd1);
        chk("lock_samps0", {16'd0, samps}, 64'd0);
        for (int i = 0; i < 3; i++) send_true();
        chk("w19_samps",  {16'd0, samps},  64'd3);
        chk("w19_errors", {16'd0, errors}, 64'd0);

        // Single corrupted word while locked.
        send_bad();
        chk("one_err_errors", {16'd0, errors}, 64'd1);
        chk("one_err_locked", {63'd0, locked}, 64'd1);
        chk("one_err_samps",  {16'd0, samps},  64'd4);
        for (int i = 0; i < 5; i++) send_true();
        chk("after_err_samps",  {16'd0, samps},  64'd9);
        chk("after_err_errors", {16'd0, errors}, 64'd1);

        // Four consecutive corrupted words drop lock on the fourth.
        for (int i = 0; i < 3; i++) send_bad();
        chk("bad3_locked", {63'd0, locked}, 64'd1);
        chk("bad3_errors", {16'd0, errors}, 64'd4);
        send_bad();
        chk("bad4_locked", {63'd0, locked}, 64'd0);
        chk("bad4_errors", {16'd0, errors}, 64'd5);
        chk("bad4_samps",  {16'd0, samps},  64'd13);

        // Relock: seed + 16 matching words; counters hold in SEARCH.
        for (int i = 0; i < 16; i++) send_true();
        chk("relock_pre",   {63'd0, locked}, 64'd0);
        chk("relock_samps", {16'd0, samps},  64'd13);
        send_true();
        chk("relock_locked", {63'd0, locked}, 64'd1);
        chk("relock_errors", {16'd0, errors}, 64'd5);
        send_true();
        chk("relock_samps2", {16'd0, samps}, 64'd14);

        // Disable while locked: beat ignored, counters hold.
        enable = 1'b0;
        send_word(w);
        chk("dis_locked", {63'd0, locked}, 64'd0);
        chk("dis_samps",  {16'd0, samps},  64'd14);
        chk("dis_errors", {16'd0, errors}, 64'd5);
        send_word(64'h0);
        chk("dis_samps2", {16'd0, samps}, 64'd14);
        // Re-enable: counters clear on the IDLE -> SEARCH edge.
        enable = 1'b1;
        tick();
        chk("reen_samps",  {16'd0, samps},  64'd0);
        chk("reen_errors", {16'd0, errors}, 64'd0);
        chk("reen_locked", {63'd0, locked}, 64'd0);

        // Random 50% valid duty: lock still needs exactly 17 valid beats.
        vcnt = 0;
        for (int it = 0; it < 600 && vcnt < 17; it++) begin
            if ($urandom_range(0, 1) == 1 || it >= 300) begin
                send_true();
                vcnt++;
                if (vcnt == 16) chk("gap_prelock", {63'd0, locked}, 64'd0);
            end else begin
                i_tvalid = 1'b0;
                i_tdata  = {$urandom, $urandom};
                tick();
            end
        end
        chk("gap_lock",   {63'd0, locked}, 64'd1);
        chk("gap_errors", {16'd0, errors}, 64'd0);
        vcnt = 0;
        for (int it = 0; it < 600 && vcnt < 4; it++) begin
            if ($urandom_range(0, 1) == 1 || it >= 300) begin
                send_true();
                vcnt++;
            end else begin
                i_tvalid = 1'b0;
                i_tdata  = {$urandom, $urandom};
                tick();
            end
        end
        chk("gap_samps",   {16'd0, samps},  64'd4);
        chk("gap_errors2", {16'd0, errors}, 64'd0);

        // Reset while locked abandons everything.
        rst = 1'b1;
        send_word(w);
        chk("midrst_locked", {63'd0, locked}, 64'd0);
        chk("midrst_samps",  {16'd0, samps},  64'd0);
        rst = 1'b0;
        tick();

        // All-zero stream never locks.
        for (int i = 0; i < 40; i++) send_word(64'h0);
        chk("zero_locked", {63'd0, locked}, 64'd0);
        chk("zero_samps",  {16'd0, samps},  64'd0);
        chk("zero_errors", {16'd0, errors}, 64'd0);

        // Fresh seed after the zero run still locks normally.
        w = 64'h1;
        for (int i = 0; i < 17; i++) send_true();
        chk("post_zero_lock", {63'd0, locked}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
